// File: rtl/multicycle_control_if.sv
// multicycle_control_if: bundle between the multicycle control FSM and the datapath/memory.
//   master (controller): inputs run, opcode, mem_ready; drives all datapath controls,
//   status flags (illegal, bus_err, busy) and the retired-instruction count instret.
//   slave (datapath side): the mirror image.
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_src;
    logic             ir_write;
    logic             iord;
    logic             mem_req;
    logic             mem_we;
    logic             reg_write;
    logic [1:0]       mem_to_reg;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             branch;
    logic             illegal;
    logic             bus_err;
    logic             busy;
    logic [CNT_W-1:0] instret;

    modport master (
        input  run, opcode, mem_ready,
        output pc_write, pc_src, ir_write, iord, mem_req, mem_we, reg_write,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, branch,
               illegal, bus_err, busy, instret
    );

    modport slave (
        output run, opcode, mem_ready,
        input  pc_write, pc_src, ir_write, iord, mem_req, mem_we, reg_write,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, branch,
               illegal, bus_err, busy, instret
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: RV32I multicycle main control FSM.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - master side of multicycle_control_if: run/opcode/mem_ready in,
//           datapath enables and mux selects, sticky illegal/bus_err, busy and instret out.
module multicycle_control #(
    parameter bit ENABLE_JAL     = 1'b1,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_ALU_WB, S_MEM_ADDR,
        S_MEM_ACCESS, S_MEM_WB, S_BRANCH, S_JAL, S_TRAP
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // The counter only ever needs to reach TIMEOUT_CYCLES-1 before the trap fires.
    localparam int WAIT_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    state_t           state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [6:0]       op_q, op_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             stalled, timed_out, retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            op_q      <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        retire    = 1'b0;
        stalled   = (state_q == S_FETCH || state_q == S_MEM_ACCESS) && !bus.mem_ready;
        // A ready on the last allowed cycle is not a stall, so it beats the timeout.
        timed_out = stalled && (TIMEOUT_CYCLES > 0) && (wait_q == WAIT_LAST);
        case (state_q)
            S_IDLE:       state_d = bus.run ? S_FETCH : S_IDLE;
            S_FETCH:      state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                op_d = bus.opcode;
                case (bus.opcode)
                    OP_R, OP_I:   state_d = S_EXEC;
                    OP_LD, OP_ST: state_d = S_MEM_ADDR;
                    OP_BR:        state_d = S_BRANCH;
                    OP_JAL: begin
                        state_d   = ENABLE_JAL ? S_JAL : S_TRAP;
                        illegal_d = illegal_q | !ENABLE_JAL;
                    end
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC:       state_d = S_ALU_WB;
            S_MEM_ADDR:   state_d = S_MEM_ACCESS;
            S_MEM_ACCESS: begin
                retire  = bus.mem_ready && op_q == OP_ST;
                state_d = bus.mem_ready ? S_MEM_WB : S_MEM_ACCESS;
            end
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL: retire = 1'b1;
            default:      state_d = S_TRAP;
        endcase
        if (timed_out) begin
            state_d   = S_TRAP;
            bus_err_d = 1'b1;
        end
        if (retire) state_d = bus.run ? S_FETCH : S_IDLE;
        instret_d = instret_q + CNT_W'(retire);
        wait_d    = state_d != state_q ? '0 : wait_q + WAIT_W'(stalled);
    end

    always_comb begin
        bus.pc_write   = 1'b0;
        bus.pc_src     = 1'b0;
        bus.ir_write   = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_to_reg = 2'b00;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;
        bus.branch     = 1'b0;
        bus.illegal    = illegal_q;
        bus.bus_err    = bus_err_q;
        bus.busy       = state_q != S_IDLE && state_q != S_TRAP;
        case (state_q)
            S_FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b10;
            end
            S_EXEC: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = op_q == OP_R ? 2'b00 : 2'b10;
                bus.alu_op    = op_q == OP_R ? 2'b10 : 2'b11;
            end
            S_ALU_WB: bus.reg_write = 1'b1;
            S_MEM_ADDR: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
            end
            S_MEM_ACCESS: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                bus.mem_we  = op_q == OP_ST;
            end
            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 2'b01;
            end
            S_BRANCH: begin
                bus.alu_src_a = 2'b01;
                bus.alu_op    = 2'b01;
                bus.branch    = 1'b1;
                bus.pc_src    = 1'b1;
            end
            S_JAL: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 2'b10;
                bus.pc_write   = 1'b1;
                bus.pc_src     = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.instret = instret_q;
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Parametrised multicycle successor to the single-cycle main control decoder for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback states and drives datapath enables and muxes per state. It waits on a memory ready handshake with a timeout, traps on unsupported opcodes, and counts retired instructions. It sits between the instruction register (opcode) and the shared-memory multicycle datapath.

Parameters:
ENABLE_JAL, 1, 1 = decode jal (1101111); 0 = treat jal as illegal
TIMEOUT_CYCLES, 16, consecutive not-ready memory cycles before bus error; 0 disables timeout
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  enables instruction issue; sampled on entry to FETCH/IDLE
opcode  in  7  IR[6:0]; valid from DECODE until next FETCH
mem_ready  in  1  memory completes current request this cycle
pc_write  out  1  PC load enable
pc_src  out  1  0 = ALU result, 1 = ALUOut register (jump target)
ir_write  out  1  IR load enable
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_req  out  1  memory request
mem_we  out  1  memory write (store)
reg_write  out  1  register file write
mem_to_reg  out  2  00 = ALUOut, 01 = MDR, 10 = PC (link)
alu_src_a  out  2  00 = PC, 01 = rs1, 10 = old PC
alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate
alu_op  out  2  00 = add, 01 = branch compare, 10 = R-type funct, 11 = I-type funct
branch  out  1  conditional PC write (datapath gates with zero)
illegal  out  1  sticky illegal-opcode flag
bus_err  out  1  sticky memory timeout flag
busy  out  1  high in every state except IDLE and TRAP
instret  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W

Behaviour:
- rst_n low: state = IDLE, instret = 0, wait counter = 0, illegal = bus_err = 0, latched opcode = 0. Every output is 0 during reset and in IDLE.
- Outputs are Moore decodes of state and latched opcode, except ir_write/pc_write in FETCH, which also depend on mem_ready.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH: mem_req=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=00. When mem_ready=1 in the same cycle, ir_write=1 and pc_write=1 (pc_src=0), and next state is DECODE.
- DECODE: opcode is latched. alu_src_a=10, alu_src_b=10, alu_op=00 (branch/jump target into ALUOut). Next state by opcode:
  - 0110011 or 0010011 -> EXEC
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL if ENABLE_JAL, else TRAP
  - any other opcode -> TRAP, and illegal is set
- EXEC: alu_src_a=01. R-type: alu_src_b=00, alu_op=10. I-type: alu_src_b=10, alu_op=11. Next state ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=00. Retires.
- MEM_ADDR: alu_src_a=01, alu_src_b=10, alu_op=00. Next state MEM_ACCESS.
- MEM_ACCESS: mem_req=1, iord=1, mem_we=1 for store only. Holds until mem_ready. Store retires; load -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=01. Retires.
- BRANCH: alu_src_a=01, alu_src_b=00, alu_op=01, branch=1, pc_src=1. Retires.
- JAL: reg_write=1, mem_to_reg=10, pc_write=1, pc_src=1. Retires.
- Retire: instret increments by 1 on the retiring edge. Next state is FETCH if run=1, else IDLE.
- Timeout: the wait counter clears on every state change. It increments each FETCH/MEM_ACCESS cycle with mem_ready=0.
  - With TIMEOUT_CYCLES=N>0, the Nth consecutive not-ready cycle moves the FSM to TRAP and sets bus_err.
  - mem_ready=1 on that same cycle wins: the access completes and no error is raised.
- TRAP: all outputs 0 except the sticky illegal/bus_err flag. Exit only via rst_n. instret is unchanged.
- Reset mid-instruction aborts immediately; no partial writeback is signalled.

Test Plan:
- Reset, run=1, opcode=0110011, mem_ready=1 -> FETCH, DECODE, EXEC (alu_op=10, alu_src_b=00), ALU_WB (reg_write=1); instret=1 after 4 cycles.
- Load 0000011, mem_ready low 3 cycles in MEM_ACCESS -> mem_req=iord=1 held 4 cycles, mem_we=0, then MEM_WB with mem_to_reg=01; instret+1.
- Store 0100011 -> mem_we=1 only in MEM_ACCESS, reg_write never 1, returns to FETCH; run=0 at retire -> IDLE with all outputs 0.
- Opcode 1111111, and jal with ENABLE_JAL=0 -> TRAP, illegal=1, busy=0, instret unchanged, held until rst_n pulse.
- TIMEOUT_CYCLES=4, mem_ready=0 in FETCH -> TRAP after 4 cycles, bus_err=1; repeat with mem_ready=1 on 4th cycle -> DECODE, no error.
- rst_n asserted mid MEM_ACCESS of a load -> all outputs 0 immediately, instret=0, no reg_write; branch 1100011 afterwards -> branch=1, alu_op=01 in BRANCH.
